// File: rtl/pcap_pkg.sv
// pcap_pkg: FSM states, IRQ status bit positions and burst default shared by the PCAP DMA block.
package pcap_pkg;
    typedef enum logic [2:0] {S_IDLE, S_FILL, S_REQ, S_BURST, S_DONE} state_t;
    localparam int BURST_LEN_DEF = 16;
    localparam int ST_BLK_DONE = 0;
    localparam int ST_LAST = 1;
    localparam int ST_TIMEOUT = 2;
    localparam int ST_ADDR_ERR = 3;
    localparam int ST_OVERRUN = 4;
endpackage

// File: rtl/pcap_dma_fifo.sv
// pcap_dma_fifo: first-word-fall-through sample FIFO with occupancy count; reads as zero when empty.
module pcap_dma_fifo #(
    parameter int FIFO_AW = 10
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               flush_i,
    input  logic               wr_i,
    input  logic [31:0]        dat_i,
    input  logic               rd_i,
    output logic [31:0]        dat_o,
    output logic [FIFO_AW:0]   count_o,
    output logic               full_o,
    output logic               empty_o
);
    logic [31:0] mem [2**FIFO_AW];
    logic [FIFO_AW-1:0] wp, rp;
    logic push, pop;

    assign empty_o = count_o == '0;
    assign full_o = count_o[FIFO_AW];
    assign pop = rd_i && !empty_o;
    // A write into a full FIFO still lands when a read frees a slot in the same cycle
    assign push = wr_i && (!full_o || pop);
    assign dat_o = empty_o ? '0 : mem[rp];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wp <= '0;
            rp <= '0;
            count_o <= '0;
        end else if (flush_i) begin
            wp <= '0;
            rp <= '0;
            count_o <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            count_o <= count_o + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wp] <= dat_i;
    end
endmodule

// File: rtl/pcap_dma_block_ctrl.sv
// pcap_dma_block_ctrl: packs captured words into ping-pong DMA blocks via fixed-length write bursts.
// Define PCAP_DMA_TIMEOUT_EN to flush partial blocks after timeout_i idle clocks.
module pcap_dma_block_ctrl
    import pcap_pkg::*;
#(
    parameter int FIFO_AW = 10,
    parameter int BURST_LEN = BURST_LEN_DEF
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic [31:0] pcap_dat_i,
    input  logic        pcap_wstb_i,
    input  logic        pcap_done_i,
    input  logic [31:0] block_size_i,
    input  logic [31:0] timeout_i,
    input  logic        dma_reset_i,
    input  logic        dma_start_i,
    input  logic [31:0] dma_addr_i,
    input  logic        dma_addr_wstb_i,
    output logic        wr_req_o,
    output logic [31:0] wr_addr_o,
    input  logic        wr_ack_i,
    input  logic        wr_rd_i,
    output logic [31:0] wr_dat_o,
    output logic        irq_o,
    output logic [7:0]  irq_status_o,
    output logic [31:0] smpl_count_o
);
    localparam logic [31:0] BURST_BYTES = 32'(4 * BURST_LEN);
    localparam logic [FIFO_AW:0] BL = (FIFO_AW+1)'(BURST_LEN);

    state_t state, state_nx;
    logic [31:0] cur_addr, next_addr, offset, fdat;
    logic [FIFO_AW:0] fcount;
    logic [4:0] beat, fill_words;
    logic [7:0] status;
    logic next_valid, pend_last, ovr, pad, tmo;
    logic ffull, fempty, fpush, frd, overrun, last, term, swap, tmo_hit;

    assign fpush = pcap_wstb_i && state != S_IDLE && !dma_reset_i;
    // Padded beats past the real words are never popped from the FIFO
    assign frd = wr_rd_i && state == S_REQ && (!pad || beat < fill_words);
    assign overrun = fpush && ffull && !frd;
    assign last = pend_last || ovr;
    assign term = last && (pad || fempty);
    assign swap = next_valid && ((state == S_IDLE && dma_start_i) || (state == S_DONE && !term));
    assign wr_req_o = state == S_REQ;
    assign wr_addr_o = cur_addr + offset;
    assign wr_dat_o = (pad && beat >= fill_words) ? '0 : fdat;

    pcap_dma_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
        .clk_i(clk_i),
        .reset_n_i(reset_n_i),
        .flush_i(dma_reset_i),
        .wr_i(fpush),
        .dat_i(pcap_dat_i),
        .rd_i(frd),
        .dat_o(fdat),
        .count_o(fcount),
        .full_o(ffull),
        .empty_o(fempty)
    );

`ifdef PCAP_DMA_TIMEOUT_EN
    logic [31:0] tmo_cnt;
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) tmo_cnt <= '0;
        else if (dma_reset_i) tmo_cnt <= '0;
        else if (pcap_wstb_i) tmo_cnt <= timeout_i;
        else if (state == S_FILL && tmo_cnt != '0) tmo_cnt <= tmo_cnt - 1'b1;
    end
    assign tmo_hit = state == S_FILL && timeout_i != '0 && tmo_cnt == 32'd1 && !pcap_wstb_i
                     && (offset != '0 || !fempty);
`else
    logic unused_timeout;
    assign unused_timeout = ^timeout_i;
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = (dma_start_i && next_valid) ? S_FILL : S_IDLE;
            S_FILL:  state_nx = fcount >= BL ? S_REQ : (last || tmo_hit) ? (fempty ? S_DONE : S_REQ) : S_FILL;
            S_REQ:   state_nx = wr_ack_i ? S_BURST : S_REQ;
            S_BURST: state_nx = (pad || offset + BURST_BYTES == block_size_i) ? S_DONE : S_FILL;
            S_DONE:  state_nx = (!term && next_valid) ? S_FILL : S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        status = '0;
        status[ST_BLK_DONE] = offset == block_size_i && !pad;
        status[ST_LAST] = term;
        status[ST_TIMEOUT] = tmo;
        status[ST_ADDR_ERR] = !term && !next_valid;
        status[ST_OVERRUN] = term && ovr;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= S_IDLE;
            cur_addr <= '0;
            next_addr <= '0;
            next_valid <= 1'b0;
            offset <= '0;
            pend_last <= 1'b0;
            ovr <= 1'b0;
            pad <= 1'b0;
            tmo <= 1'b0;
            beat <= '0;
            fill_words <= '0;
            irq_o <= 1'b0;
            irq_status_o <= '0;
            smpl_count_o <= '0;
        end else if (dma_reset_i) begin
            state <= S_IDLE;
            cur_addr <= '0;
            next_addr <= '0;
            next_valid <= 1'b0;
            offset <= '0;
            pend_last <= 1'b0;
            ovr <= 1'b0;
            pad <= 1'b0;
            tmo <= 1'b0;
            beat <= '0;
            irq_o <= 1'b0;
        end else begin
            state <= state_nx;
            irq_o <= state == S_DONE;
            beat <= state == S_REQ ? beat + 5'(wr_rd_i) : '0;
            if (dma_addr_wstb_i) next_addr <= dma_addr_i;
            next_valid <= dma_addr_wstb_i || (next_valid && !swap);
            if (swap) cur_addr <= next_addr;
            pend_last <= (pend_last && !(state == S_DONE && !swap)) || (pcap_done_i && (state == S_FILL || state == S_REQ));
            ovr <= (ovr && !(state == S_DONE && !swap)) || overrun;
            if (state == S_FILL) begin
                pad <= fcount < BL && (last || tmo_hit) && !fempty;
                fill_words <= 5'(fcount);
                tmo <= tmo || (fcount < BL && tmo_hit);
            end
            if (state == S_BURST) offset <= offset + BURST_BYTES;
            if (state == S_DONE) begin
                irq_status_o <= status;
                smpl_count_o <= (offset >> 2) - (pad ? 32'(BURST_LEN) - 32'(fill_words) : 32'd0);
                offset <= '0;
                pad <= 1'b0;
                tmo <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pcap_dma_block_ctrl.sv
// tb_pcap_dma_block_ctrl: directed scenarios with random data, checked against a block/burst layout model.
module tb_pcap_dma_block_ctrl;
    localparam int BL = 16;
    localparam logic [31:0] A = 32'h1000_0000;
    localparam logic [31:0] B = 32'h1000_0100;
    localparam logic [31:0] C = 32'h2000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, pcap_wstb, pcap_done, dma_reset, dma_start, dma_addr_wstb;
    logic [31:0] pcap_dat, block_size, timeout, dma_addr;
    logic wr_req, m_ack, t_ack, m_rd, irq;
    logic [31:0] wr_addr, wr_dat, smpl_count;
    logic [7:0] irq_status;

    int errors = 0;
    int checks = 0;
    bit ack_en = 1'b1;
    bit load_c = 1'b0;
    logic [31:0] addr_q[$], dat_q[$], words[$], st_q[$], sc_q[$];

    pcap_dma_block_ctrl #(.FIFO_AW(4), .BURST_LEN(BL)) dut (
        .clk_i(clk),
        .reset_n_i(reset_n),
        .pcap_dat_i(pcap_dat),
        .pcap_wstb_i(pcap_wstb),
        .pcap_done_i(pcap_done),
        .block_size_i(block_size),
        .timeout_i(timeout),
        .dma_reset_i(dma_reset),
        .dma_start_i(dma_start),
        .dma_addr_i(dma_addr),
        .dma_addr_wstb_i(dma_addr_wstb),
        .wr_req_o(wr_req),
        .wr_addr_o(wr_addr),
        .wr_ack_i(m_ack | t_ack),
        .wr_rd_i(m_rd),
        .wr_dat_o(wr_dat),
        .irq_o(irq),
        .irq_status_o(irq_status),
        .smpl_count_o(smpl_count)
    );

    // Write master: pops one burst, then acks
    initial begin
        m_rd = 1'b0;
        m_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (wr_req === 1'b1 && ack_en) begin
                addr_q.push_back(wr_addr);
                for (int i = 0; i < BL; i++) begin
                    m_rd = 1'b1;
                    dat_q.push_back(wr_dat);
                    @(negedge clk);
                end
                m_rd = 1'b0;
                m_ack = 1'b1;
                @(negedge clk);
                m_ack = 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (irq === 1'b1) begin
            st_q.push_back(32'(irq_status));
            sc_q.push_back(smpl_count);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
        return i < q.size() ? q[i] : 32'hxxxx_xxxx;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe(input logic [31:0] d);
        pcap_dat = d;
        pcap_wstb = 1'b1;
        words.push_back(d);
        @(negedge clk);
        pcap_wstb = 1'b0;
    endtask

    task automatic load_addr(input logic [31:0] a);
        dma_addr = a;
        dma_addr_wstb = 1'b1;
        @(negedge clk);
        dma_addr_wstb = 1'b0;
    endtask

    task automatic start();
        dma_start = 1'b1;
        @(negedge clk);
        dma_start = 1'b0;
    endtask

    task automatic new_scn();
        dma_reset = 1'b1;
        @(negedge clk);
        dma_reset = 1'b0;
        addr_q.delete();
        dat_q.delete();
        words.delete();
        st_q.delete();
        sc_q.delete();
    endtask

    task automatic stream(input int n);
        for (int i = 0; i < n; i++) begin
            strobe($urandom);
            tick($urandom_range(1, 3));
            if (load_c && st_q.size() >= 1) begin
                load_addr(C);
                load_c = 1'b0;
            end
        end
    endtask

    task automatic wait_irqs(input int n, input int budget, output int el);
        el = 0;
        while (st_q.size() < n && el < budget) begin
            @(negedge clk);
            el++;
        end
        chk("irq_wait", 32'(st_q.size() >= n), 32'd1);
    endtask

    // Model: n real words laid out as consecutive bursts, blocks of block_size at b0 then b1, last burst zero-padded
    task automatic check_bursts(input string tag, input logic [31:0] b0, input logic [31:0] b1, input int n);
        int nb, bpb, bad;
        nb = (n + BL - 1) / BL;
        bpb = int'(block_size) / (4 * BL);
        bad = 0;
        chk({tag, "_nbursts"}, 32'(addr_q.size()), 32'(nb));
        chk({tag, "_nwords"}, 32'(dat_q.size()), 32'(nb * BL));
        for (int k = 0; k < nb; k++)
            chk({tag, "_addr"}, qat(addr_q, k), (k / bpb == 0 ? b0 : b1) + 32'((k % bpb) * 4 * BL));
        for (int j = 0; j < nb * BL; j++)
            if (qat(dat_q, j) !== (j < n ? words[j] : 32'h0)) bad++;
        chk({tag, "_data_mismatches"}, 32'(bad), 32'd0);
    endtask

    initial begin
        int el;
        reset_n = 1'b1;
        pcap_dat = '0;
        pcap_wstb = 1'b0;
        pcap_done = 1'b0;
        block_size = 32'd256;
        timeout = '0;
        dma_reset = 1'b0;
        dma_start = 1'b0;
        dma_addr = '0;
        dma_addr_wstb = 1'b0;
        t_ack = 1'b0;
        #2 reset_n = 1'b0;
        tick(3);
        chk("rst_wr_req", 32'(wr_req), 32'd0);
        chk("rst_wr_addr", wr_addr, 32'd0);
        chk("rst_wr_dat", wr_dat, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_status", 32'(irq_status), 32'd0);
        chk("rst_smpl", smpl_count, 32'd0);
        reset_n = 1'b1;
        tick(2);

        // Two full blocks across ping-pong addresses
        new_scn();
        load_addr(A);
        start();
        load_addr(B);
        load_c = 1'b1;
        stream(128);
        wait_irqs(2, 400, el);
        tick(5);
        check_bursts("full", A, B, 128);
        chk("full_st0", qat(st_q, 0), 32'h01);
        chk("full_st1", qat(st_q, 1), 32'h01);
        chk("full_sc0", qat(sc_q, 0), 32'd64);
        chk("full_sc1", qat(sc_q, 1), 32'd64);
        chk("full_req_idle", 32'(wr_req), 32'd0);

        // End of acquisition mid-block: padded final burst
        load_c = 1'b0;
        new_scn();
        load_addr(A);
        start();
        load_addr(B);
        stream(70);
        wait_irqs(1, 300, el);
        tick(10);
        pcap_done = 1'b1;
        @(negedge clk);
        pcap_done = 1'b0;
        wait_irqs(2, 300, el);
        tick(5);
        check_bursts("last", A, B, 70);
        chk("last_st0", qat(st_q, 0), 32'h01);
        chk("last_st1", qat(st_q, 1), 32'h02);
        chk("last_sc0", qat(sc_q, 0), 32'd64);
        chk("last_sc1", qat(sc_q, 1), 32'd6);
        tick(30);
        chk("last_no_more", 32'(addr_q.size()), 32'd5);

        // Block completes without a following address
        new_scn();
        load_addr(A);
        start();
        stream(64);
        wait_irqs(1, 300, el);
        tick(5);
        chk("aerr_st", qat(st_q, 0), 32'h09);
        chk("aerr_sc", qat(sc_q, 0), 32'd64);
        check_bursts("aerr", A, A, 64);
        stream(16);
        tick(60);
        chk("aerr_idle_bursts", 32'(addr_q.size()), 32'd4);
        chk("aerr_idle_req", 32'(wr_req), 32'd0);

        // Overrun: 16-deep FIFO, ack withheld, 20 strobes
        new_scn();
        load_addr(A);
        start();
        ack_en = 1'b0;
        stream(20);
        tick(5);
        chk("ovr_req_held", 32'(wr_req), 32'd1);
        ack_en = 1'b1;
        wait_irqs(1, 200, el);
        tick(5);
        chk("ovr_st", qat(st_q, 0), 32'h12);
        chk("ovr_sc", qat(sc_q, 0), 32'd16);
        check_bursts("ovr", A, A, 16);

        // dma_reset during an outstanding request; late ack ignored
        new_scn();
        load_addr(A);
        start();
        ack_en = 1'b0;
        stream(16);
        tick(3);
        chk("rdma_req_before", 32'(wr_req), 32'd1);
        dma_reset = 1'b1;
        @(negedge clk);
        dma_reset = 1'b0;
        chk("rdma_req_after", 32'(wr_req), 32'd0);
        chk("rdma_fifo_empty", wr_dat, 32'd0);
        chk("rdma_addr", wr_addr, 32'd0);
        t_ack = 1'b1;
        @(negedge clk);
        t_ack = 1'b0;
        tick(10);
        chk("rdma_late_ack_req", 32'(wr_req), 32'd0);
        chk("rdma_late_ack_irq", 32'(st_q.size()), 32'd0);
        ack_en = 1'b1;
        start();
        stream(16);
        tick(40);
        chk("rdma_start_noaddr", 32'(addr_q.size()), 32'd0);

`ifdef PCAP_DMA_TIMEOUT_EN
        // Idle timeout flushes the partial block and stays armed
        new_scn();
        timeout = 32'd1000;
        load_addr(A);
        start();
        load_addr(B);
        stream(20);
        wait_irqs(1, 1200, el);
        chk("tmo_window", 32'(el >= 980 && el <= 1040), 32'd1);
        tick(5);
        chk("tmo_st", qat(st_q, 0), 32'h04);
        chk("tmo_sc", qat(sc_q, 0), 32'd20);
        check_bursts("tmo", A, B, 20);
        chk("tmo_req_idle", 32'(wr_req), 32'd0);
`else
        // Without the timeout build, timeout_i has no effect
        new_scn();
        timeout = 32'd50;
        load_addr(A);
        start();
        load_addr(B);
        stream(20);
        tick(300);
        chk("notmo_bursts", 32'(addr_q.size()), 32'd1);
        chk("notmo_irqs", 32'(st_q.size()), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
